// File: rtl/dmem_pkg.sv
// Shared types and defaults for the latency-controlled data memory.
// The lat_cnt_w helper sizes the load countdown field for a given load latency.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_CNT_W  = 16;

  function automatic int lat_cnt_w(input int rd_lat);
    return $clog2(rd_lat + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear.
// The clear has priority over an increment that arrives in the same cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dmem_latency_ctrl.sv
// MEM-stage data memory: single-cycle posted stores, RD_LAT-cycle loads that stall
// the pipeline, sticky out-of-range flag and saturating load/store/stall statistics.
module dmem_latency_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = DMEM_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic              i_clr_stats,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdata_valid,
  output logic              o_addr_err,
  output logic [CNT_W-1:0]  o_stat_loads,
  output logic [CNT_W-1:0]  o_stat_stores,
  output logic [CNT_W-1:0]  o_stat_stall
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam int                LCW      = lat_cnt_w(RD_LAT);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [LCW-1:0]    BUSY_CYC = LCW'(RD_LAT - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [LCW-1:0]      r_cnt;
  logic [LCW-1:0]      w_cnt_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_addr_oor;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_mem_q;
  logic                r_rd_zero;
  logic                r_addr_err;

  logic                w_accept;
  logic                w_load_acc;
  logic                w_store_acc;
  logic                w_req_oor;
  logic                w_rd_en;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_rd_oor;
  logic                w_stall;

  assign w_accept    = (r_state == IDLE) && i_req_valid;
  assign w_load_acc  = w_accept && !i_req_we;
  assign w_store_acc = w_accept && i_req_we;
  assign w_req_oor   = ({1'b0, i_req_addr} >= DEPTH_A);

  // The memory is read on the edge that enters DONE; with RD_LAT=1 that edge is
  // the accepting edge itself, so the live request address is used directly.
  assign w_rd_en   = (w_state_next == DONE) && (r_state != DONE);
  assign w_rd_addr = (r_state == IDLE) ? i_req_addr : r_addr;
  assign w_rd_oor  = (r_state == IDLE) ? w_req_oor : r_addr_oor;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_load_acc) begin
          if (RD_LAT == 1) begin
            w_state_next = DONE;
          end else begin
            w_state_next = BUSY;
            w_cnt_next   = BUSY_CYC;
          end
        end
      end
      BUSY: begin
        if (r_cnt == LCW'(1)) begin
          w_state_next = DONE;
        end else begin
          w_cnt_next = r_cnt - LCW'(1);
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_addr_oor <= 1'b0;
      r_rd_zero  <= 1'b1;
      r_addr_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_load_acc) begin
        r_addr     <= i_req_addr;
        r_addr_oor <= w_req_oor;
      end
      if (w_rd_en) begin
        r_rd_zero <= w_rd_oor;
      end
      if (i_clr_stats) begin
        r_addr_err <= 1'b0;
      end else if (w_accept && w_req_oor) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  // Array kept free of reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge clk) begin
    if (w_store_acc && !w_req_oor) begin
      r_mem[i_req_addr[IDX_W-1:0]] <= i_req_wdata;
    end
    if (w_rd_en) begin
      r_mem_q <= r_mem[w_rd_addr[IDX_W-1:0]];
    end
  end

  assign w_stall       = w_load_acc || (r_state == BUSY);
  assign o_stall       = w_stall;
  assign o_rdata_valid = (r_state == DONE);
  assign o_rdata       = r_rd_zero ? '0 : r_mem_q;
  assign o_addr_err    = r_addr_err;

  sat_counter #(.W(CNT_W)) u_cnt_loads (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_load_acc),
    .i_clr   (i_clr_stats),
    .o_count (o_stat_loads)
  );

  sat_counter #(.W(CNT_W)) u_cnt_stores (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_store_acc),
    .i_clr   (i_clr_stats),
    .o_count (o_stat_stores)
  );

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_stall),
    .i_clr   (i_clr_stats),
    .o_count (o_stat_stall)
  );

endmodule

// File: tb/tb_dmem_latency_ctrl.sv
// Three instances (RD_LAT 2/1/4, the last with 4-bit counters) checked every cycle
// against a transaction-level model of loads, stores, stalls and statistics.
module tb_dmem_latency_ctrl;

  localparam int NI    = 3;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n       [NI];
  logic        req_valid   [NI];
  logic        req_we      [NI];
  logic [15:0] req_addr    [NI];
  logic [15:0] req_wdata   [NI];
  logic        clr         [NI];
  logic        stall       [NI];
  logic        rdata_valid [NI];
  logic        addr_err    [NI];
  logic [15:0] rdata       [NI];
  logic [15:0] s_loads     [NI];
  logic [15:0] s_stores    [NI];
  logic [15:0] s_stall     [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LATP = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
    localparam int CW   = (gi == 2) ? 4 : 16;
    logic [CW-1:0] w_l, w_s, w_t;
    dmem_latency_ctrl #(
      .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RD_LAT(LATP), .CNT_W(CW)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n[gi]),
      .i_req_valid   (req_valid[gi]),
      .i_req_we      (req_we[gi]),
      .i_req_addr    (req_addr[gi]),
      .i_req_wdata   (req_wdata[gi]),
      .i_clr_stats   (clr[gi]),
      .o_stall       (stall[gi]),
      .o_rdata       (rdata[gi]),
      .o_rdata_valid (rdata_valid[gi]),
      .o_addr_err    (addr_err[gi]),
      .o_stat_loads  (w_l),
      .o_stat_stores (w_s),
      .o_stat_stall  (w_t)
    );
    assign s_loads[gi]  = 16'(w_l);
    assign s_stores[gi] = 16'(w_s);
    assign s_stall[gi]  = 16'(w_t);
  end

  // Reference model: a load accepted in cycle T stalls T..T+lat-1 and returns in T+lat.
  logic [15:0] m_mem   [NI][DEPTH];
  int          m_left  [NI];
  bit          m_done  [NI];
  logic [15:0] m_pend  [NI];
  logic [15:0] m_rdata [NI];
  int          m_loads [NI];
  int          m_stores[NI];
  int          m_stall [NI];
  bit          m_aerr  [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic int cmax(int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic int sat_inc(int k, int v);
    return (v >= cmax(k)) ? v : v + 1;
  endfunction

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset(int k);
    m_left[k]   = 0;
    m_done[k]   = 1'b0;
    m_pend[k]   = '0;
    m_rdata[k]  = '0;
    m_loads[k]  = 0;
    m_stores[k] = 0;
    m_stall[k]  = 0;
    m_aerr[k]   = 1'b0;
  endtask

  function automatic bit exp_stall(int k);
    bit idle;
    idle = (m_left[k] == 0) && !m_done[k];
    return (idle && req_valid[k] && !req_we[k]) || (m_left[k] > 0);
  endfunction

  task automatic check_outputs(int k);
    chk("stall",  k, 32'(stall[k]),       32'(exp_stall(k)));
    chk("rvalid", k, 32'(rdata_valid[k]), 32'(m_done[k]));
    chk("rdata",  k, 32'(rdata[k]),       32'(m_done[k] ? m_pend[k] : m_rdata[k]));
    chk("aerr",   k, 32'(addr_err[k]),    32'(m_aerr[k]));
    chk("loads",  k, 32'(s_loads[k]),     32'(m_loads[k]));
    chk("stores", k, 32'(s_stores[k]),    32'(m_stores[k]));
    chk("nstall", k, 32'(s_stall[k]),     32'(m_stall[k]));
  endtask

  task automatic model_edge(int k);
    bit st;
    bit oor;
    int a;
    st = exp_stall(k);
    a  = int'(req_addr[k]);
    if (m_done[k]) begin
      m_done[k]  = 1'b0;
      m_rdata[k] = m_pend[k];
    end else if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) m_done[k] = 1'b1;
    end else if (req_valid[k]) begin
      oor = (a >= DEPTH);
      if (oor) m_aerr[k] = 1'b1;
      if (req_we[k]) begin
        m_stores[k] = sat_inc(k, m_stores[k]);
        if (!oor) m_mem[k][a] = req_wdata[k];
      end else begin
        m_loads[k] = sat_inc(k, m_loads[k]);
        m_pend[k]  = oor ? 16'h0 : m_mem[k][a];
        m_left[k]  = lat_of(k) - 1;
        if (m_left[k] == 0) m_done[k] = 1'b1;
      end
    end
    if (st) m_stall[k] = sat_inc(k, m_stall[k]);
    if (clr[k]) begin
      m_loads[k]  = 0;
      m_stores[k] = 0;
      m_stall[k]  = 0;
      m_aerr[k]   = 1'b0;
    end
  endtask

  // Entered and left at posedge+1; outputs are sampled mid-cycle.
  task automatic step(int k, bit v, bit we, logic [15:0] a, logic [15:0] wd, bit c);
    for (int j = 0; j < NI; j++) begin
      if (j != k) begin
        req_valid[j] = 1'b0;
        clr[j]       = 1'b0;
      end
    end
    req_valid[k] = v;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    clr[k]       = c;
    #2;
    check_outputs(k);
    @(posedge clk);
    #1;
    model_edge(k);
  endtask

  task automatic do_store(int k, logic [15:0] a, logic [15:0] wd, bit c);
    step(k, 1'b1, 1'b1, a, wd, c);
  endtask

  // The request is held until the model says the load has returned, as the pipeline would.
  task automatic do_load(int k, logic [15:0] a, bit c);
    step(k, 1'b1, 1'b0, a, 16'h0, c);
    for (int n = 0; n < 16 && (m_left[k] > 0 || m_done[k]); n++) begin
      step(k, 1'b1, 1'b0, a, 16'h0, 1'b0);
    end
  endtask

  task automatic do_idle(int k, bit c);
    step(k, 1'b0, 1'b0, 16'h0, 16'h0, c);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      clr[k]       = 1'b0;
      model_reset(k);
    end
    #3;
    for (int k = 0; k < NI; k++) check_outputs(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < DEPTH; a++) do_store(k, 16'(a), 16'($urandom), 1'b0);
      do_idle(k, 1'b1);
    end

    // RD_LAT=2: store then load the same word on the next cycle.
    do_store(0, 16'd5, 16'h1234, 1'b0);
    do_load(0, 16'd5, 1'b0);
    do_idle(0, 1'b0);
    chk("tp1_rdata",  0, 32'(rdata[0]),    32'h1234);
    chk("tp1_loads",  0, 32'(s_loads[0]),  32'd1);
    chk("tp1_stores", 0, 32'(s_stores[0]), 32'd1);
    chk("tp1_stall",  0, 32'(s_stall[0]),  32'd2);

    // RD_LAT=1: three back-to-back loads.
    do_store(1, 16'd0, 16'h000A, 1'b0);
    do_store(1, 16'd1, 16'h000B, 1'b0);
    do_store(1, 16'd2, 16'h000C, 1'b1);
    for (int a = 0; a < 3; a++) do_load(1, 16'(a), 1'b0);
    do_idle(1, 1'b0);
    chk("tp2_rdata", 1, 32'(rdata[1]),   32'h000C);
    chk("tp2_loads", 1, 32'(s_loads[1]), 32'd3);
    chk("tp2_stall", 1, 32'(s_stall[1]), 32'd3);

    // Out-of-range store is dropped and must not alias onto 300 mod 256.
    do_store(0, 16'd44, 16'h0BEE, 1'b0);
    do_store(0, 16'd300, 16'hFFFF, 1'b0);
    do_load(0, 16'd300, 1'b0);
    do_idle(0, 1'b0);
    chk("tp3_aerr",  0, 32'(addr_err[0]), 32'd1);
    chk("tp3_rdata", 0, 32'(rdata[0]),    32'h0);
    do_load(0, 16'd44, 1'b0);
    do_idle(0, 1'b1);
    chk("tp3_alias", 0, 32'(rdata[0]),    32'h0BEE);

    // RD_LAT=4: asynchronous reset while BUSY aborts the load.
    do_idle(2, 1'b1);
    step(2, 1'b1, 1'b0, 16'd7, 16'h0, 1'b0);
    step(2, 1'b1, 1'b0, 16'd7, 16'h0, 1'b0);
    req_valid[2] = 1'b0;
    rst_n[2]     = 1'b0;
    model_reset(2);
    #1;
    chk("tp4_stall",  2, 32'(stall[2]),       32'd0);
    chk("tp4_rvalid", 2, 32'(rdata_valid[2]), 32'd0);
    @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    for (int n = 0; n < 6; n++) do_idle(2, 1'b0);
    do_load(2, 16'd7, 1'b0);
    chk("tp4_nstall", 2, 32'(s_stall[2]), 32'd4);

    // CNT_W=4: saturation, then clear beats a same-cycle store.
    do_idle(2, 1'b1);
    for (int n = 0; n < 20; n++) do_store(2, 16'(n), 16'(n * 3), 1'b0);
    chk("tp5_sat", 2, 32'(s_stores[2]), 32'd15);
    do_store(2, 16'd1, 16'h55AA, 1'b1);
    do_idle(2, 1'b0);
    chk("tp5_clr", 2, 32'(s_stores[2]), 32'd0);

    // Randomised traffic on every instance.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 150; n++) begin
        int          op;
        bit          c;
        logic [15:0] a;
        op = int'($urandom_range(0, 9));
        c  = ($urandom_range(0, 29) == 0);
        a  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 1023))
                                          : 16'($urandom_range(0, DEPTH - 1));
        if (op < 2)      do_idle(k, c);
        else if (op < 6) do_store(k, a, 16'($urandom), c);
        else             do_load(k, a, c);
      end
      do_idle(k, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
